// File: rtl/disp_col_window.sv
// Streaming 3-row column window (top/mid/bot) over two internal line buffers; optional DISP_COL_REPLICATE_EN.
// Latency 1 cycle (registered outputs); no backpressure, downstream must take one column per cycle.
module disp_col_window #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 640,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_top,
  output logic [WIDTH-1:0] out_mid,
  output logic [WIDTH-1:0] out_bot,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             out_eol
);

  localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YMAX  = '1;

  // la holds row y-1, lb holds row y-2; contents are never reset
  logic [WIDTH-1:0] la [IMG_W];
  logic [WIDTH-1:0] lb [IMG_W];

  logic [XW-1:0]    x_q, x_cur;
  logic [YW-1:0]    y_q, y_cur;
  logic [WIDTH-1:0] rd_a, rd_b, top_sel;
  logic             last_col, emit;

  // A start-of-frame pixel is forced to (0,0) whatever the counters say
  always_comb begin
    x_cur = in_sof ? '0 : x_q;
    y_cur = in_sof ? '0 : y_q;
  end

  assign rd_a     = la[x_cur];
  assign rd_b     = lb[x_cur];
  assign last_col = (x_cur == XLAST);

`ifdef DISP_COL_REPLICATE_EN
  // Row 1 has no row above its top neighbour, so row 0 stands in for it
  assign emit    = in_valid && (y_cur != '0);
  assign top_sel = (y_cur == YW'(1)) ? rd_a : rd_b;
`else
  assign emit    = in_valid && (y_cur >= YW'(2));
  assign top_sel = rd_b;
`endif

  // Read-before-write: this cycle's reads see the old contents at x_cur
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb[x_cur] <= rd_a;
      la[x_cur] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        x_q <= '0;
        y_q <= (y_cur == YMAX) ? YMAX : y_cur + YW'(1);
      end else begin
        x_q <= x_cur + XW'(1);
        y_q <= y_cur;
      end
    end
  end

  // Data outputs hold their last column between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_top   <= '0;
      out_mid   <= '0;
      out_bot   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_top <= top_sel;
        out_mid <= rd_a;
        out_bot <= in_data;
        out_x   <= x_cur;
        out_y   <= y_cur - YW'(1);
        out_eol <= last_col;
      end
    end
  end

endmodule

// File: doc/disp_col_window.md
# disp_col_window

Streaming column-window generator for the disparity post-processing median filter. It accepts one raster-order disparity pixel per valid cycle and stores the two previous rows in internal line buffers. For each pixel it emits the vertically aligned 3-pixel column (top/mid/bot), which feeds the downstream 3-input sorter stage. It also emits the center-row coordinates and an end-of-line flag.

## Interface
- WIDTH, 16, disparity pixel width in bits
- IMG_W, 640, pixels per image row (>= 2)
- XW, 10, width of column counter; 2^XW >= IMG_W
- YW, 10, width of row counter output
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  in_data is a valid pixel this cycle
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_data  in  WIDTH  disparity pixel, raster order
- out_valid  out  1  column outputs valid this cycle
- out_top  out  WIDTH  pixel at (x, center_row-1)
- out_mid  out  WIDTH  pixel at (x, center_row)
- out_bot  out  WIDTH  pixel at (x, center_row+1)
- out_x  out  XW  column index of emitted column
- out_y  out  YW  center row index
- out_eol  out  1  emitted column is x = IMG_W-1

## Operation
- Two line buffers LA, LB, IMG_W x WIDTH each; LA holds row y-1, LB holds row y-2.
- Counters x (0..IMG_W-1) and y (saturating at 2^YW-1). They advance only on accepted pixels.
- Accepted pixel (in_valid=1) at (x,y):
  - read a=LA[x], b=LB[x];
  - write LB[x]<=a and LA[x]<=in_data in the same cycle (read-before-write at the same address).
  - Result: top=b, mid=a, bot=in_data, center row y-1.
- Counter update: if x==IMG_W-1 then x<=0, y<=y+1; else x<=x+1.
- in_sof with in_valid: the pixel is treated as (0,0) regardless of current counters. Counters become x=1, y=0 after it. in_sof without in_valid is ignored.
- Emission (default): out_valid only for accepted pixels with y>=2. out_y=y-1, out_x=x, out_eol=(x==IMG_W-1).
- Rows 0 and 1 only fill the buffers; no output. The last image row is never a center row.
- Gaps (in_valid=0) are allowed anywhere. State holds and no output is produced.
- No backpressure; the downstream stage must accept one column per cycle.
- Line buffer contents are not reset. Stale data is never emitted because of the y>=2 gating.

## Timing
- Latency: 1 cycle. Outputs are registered and appear the cycle after in_valid.
- out_valid is a single-cycle pulse per emitted column. The data outputs hold their value while out_valid=0.
- Reset values: out_valid=0, out_top/out_mid/out_bot=0, out_x=0, out_y=0, out_eol=0; internal x=0, y=0.
- Reset mid-frame: outputs clear immediately. The first pixel after reset is (0,0) even without in_sof.
- in_sof mid-line: the partial line is abandoned and no output is produced for that pixel.
- Throughput: 1 pixel/cycle sustained. The line buffers need one read port and one write port per cycle.

## Configuration
- DISP_COL_REPLICATE_EN defined:
  - rows y>=1 also emit; for y==1, out_top=out_mid=LA[x] (row 0 replicated), out_bot=in_data, out_y=0.
  - Every row except the last becomes a center row.
- DISP_COL_REPLICATE_EN undefined: rows 0 and 1 emit nothing, as in Operation.

## Test plan
- Reset then stream IMG_W=4, 4 rows, pixel=10*y+x with in_sof on the first -> 8 out_valid pulses. First pulse: top=0, mid=10, bot=20, out_x=0, out_y=1. Last pulse: top=13, mid=23, bot=33, out_y=2, out_eol=1.
- Same stream with random in_valid gaps -> identical output sequence. Each output appears exactly 1 cycle after its pixel. out_valid is never high during gaps without a preceding pixel.
- Mid-row 2 (x=2) assert in_sof -> that pixel is (0,0) with no output. A new frame of 3 rows produces outputs only from its row 2.
- Assert rst_n=0 asynchronously during row 3 -> outputs are 0 in the same cycle. The first post-reset pixel is treated as (0,0), with no output until the third row.
- With DISP_COL_REPLICATE_EN, IMG_W=4 stream -> 12 pulses. First pulse: top=0, mid=0, bot=10, out_y=0.
- IMG_W=2 back-to-back 2 frames -> wrap at x=1 each line and correct out_eol. The second frame's row 0/1 outputs are suppressed (default build).
